periph_bus_arbiter: RTL
=======================

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clock and reset_n.
REQ-002 The block SHALL have the following ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  async active-low reset.
- req  in  2  per-requester transaction request; bit 0 = CPU, bit 1 = debug/DMA.
- req_mode  in  2  per-requester mode; 1 = write, 0 = read.
- req_address  in  2x32  per-requester register address.
- req_wdata  in  2x32  per-requester write data.
- req_lock  in  2  per-requester bus-lock hint; used only with PERIPH_ARB_LOCK_EN.
- grant  out  2  one-hot owner of the current transaction.
- done  out  2  one-cycle completion pulse to the owner.
- rdata  out  32  read data, valid while done is high.
- periph_address  out  32  address to the peripheral register block.
- periph_mode  out  1  mode to the peripheral register block.
- periph_data_in  out  32  write data to the peripheral register block.
- periph_data_out  in  32  combinational read data from the peripheral register block.

Function
REQ-003 The block SHALL implement the states IDLE, ACCESS and RESP.
REQ-004 IDLE: sample req each cycle; on any bit set, choose a winner, load the registered grant and periph_* fields from the winner's inputs, and move to ACCESS.
REQ-005 Arbitration SHALL be round-robin:
- When both bits are set, the winner is the port not granted last.
- When one bit is set, that port wins.
- last_grant updates on each grant.
REQ-006 ACCESS lasts exactly one cycle with grant and periph_* stable.
- A write commits at the ACCESS-ending clock edge.
- rdata captures periph_data_out at the same edge on reads; rdata holds its previous value on writes.
REQ-007 RESP lasts exactly one cycle.
- done[owner] = 1 and grant is held.
- The next state is IDLE.
REQ-008 Latency SHALL be as follows:
- req is sampled in cycle N.
- grant and the bus are driven in cycle N+1.
- done and rdata are valid in cycle N+2.
- The next grant is no earlier than N+4.
- Back-to-back throughput is one transaction per 3 cycles.
REQ-009 Requesters SHALL hold req, req_mode, req_address and req_wdata stable from req assertion until done. The arbiter SHALL ignore changes to these inputs after the IDLE sample edge.
REQ-010 A req deasserted during ACCESS or RESP SHALL NOT abort the transaction; done still pulses.
REQ-011 Outside ACCESS and RESP the bus SHALL be idle: periph_mode = 0 (read), periph_address = 0, periph_data_in = 0, grant = 0.
REQ-012 done SHALL be zero in all states except RESP, and at most one done bit SHALL be set.
REQ-013 A requester SHALL NOT be granted a second transaction without first receiving done for the current one.

Reset
REQ-014 Asserting reset_n low SHALL immediately force the following, including mid-transaction:
- state = IDLE.
- grant, done, rdata = 0.
- periph_mode, periph_address, periph_data_in = 0.
- last_grant = port 1, so port 0 wins the first contention.
- lock count = 0.
REQ-015 A write in ACCESS interrupted by reset SHALL NOT produce a done pulse.
REQ-016 After reset_n is released, the first req SHALL be sampled on the first rising edge.

Configuration
REQ-017 With PERIPH_ARB_LOCK_EN defined, the following SHALL apply:
- If req_lock[owner] = 1 during RESP, the next IDLE arbitration grants the same owner when its req is set, overriding round-robin.
- A 3-bit lock count increments per locked grant.
- After 4 consecutive locked grants, the next arbitration reverts to round-robin and the count clears.
- The count also clears on any unlocked grant.
REQ-018 Without PERIPH_ARB_LOCK_EN, req_lock SHALL be ignored, there SHALL be no lock-count register, and arbitration SHALL be pure round-robin.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- Single write: port 0 writes addr 32'h23, data 32'h0000_00A5 -> periph_mode = 1 for one cycle at N+1, done[0] at N+2; a subsequent read of 32'h23 returns 32'h0000_00A5.
- Contention after reset: both ports request in the same cycle -> grant = 2'b01 first; done[0], then grant = 2'b10, then done[1]; order alternates thereafter.
- Read path: port 1 reads 32'h26 with periph_data_out = 32'h0000_0F0F -> rdata = 32'h0000_0F0F while done[1] is high.
- Mid-transaction reset: reset_n low during ACCESS -> all outputs zero asynchronously, no done; operation resumes cleanly afterwards.
- Early release: req[0] dropped in ACCESS -> done[0] still pulses once, and no second grant follows.
- Lock (PERIPH_ARB_LOCK_EN only): port 0 asserts lock for 6 writes with port 1 requesting -> port 0 wins 4 consecutive transactions, then port 1 is granted.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
// Two-requester (CPU = port 0, debug/DMA = port 1) round-robin arbiter in front
// of a peripheral register block. A transaction is sampled in IDLE, driven on the
// bus for one ACCESS cycle, and acknowledged by a one-cycle done pulse in RESP.
// Optional feature: define PERIPH_ARB_LOCK_EN to honour req_lock, which lets the
// current owner keep the bus for up to four consecutive locked grants.
module periph_bus_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_mode,
  input  logic [63:0] req_address,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_lock,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic [31:0] periph_address,
  output logic        periph_mode,
  output logic [31:0] periph_data_in,
  input  logic [31:0] periph_data_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last;        // port that received the most recent grant
  logic [1:0]  r_grant;
  logic [1:0]  r_done;
  logic [31:0] r_rdata;
  logic [31:0] r_paddr;
  logic        r_pmode;
  logic [31:0] r_pdata;

  logic        w_winner;
  logic        w_last_nxt;
  logic [1:0]  w_grant_nxt;
  logic [1:0]  w_done_nxt;
  logic [31:0] w_rdata_nxt;
  logic [31:0] w_paddr_nxt;
  logic        w_pmode_nxt;
  logic [31:0] w_pdata_nxt;

`ifdef PERIPH_ARB_LOCK_EN
  logic [2:0]  r_lock_cnt;    // consecutive locked grants so far
  logic        r_lock_pend;   // previous owner asked to keep the bus
  logic [2:0]  w_lock_cnt_nxt;
  logic        w_lock_pend_nxt;
  logic        w_lock_hit;
`else
  // Lock hint has no function in this build; fold it so it is visibly consumed.
  logic        w_unused_lock;
  assign w_unused_lock = ^req_lock;
`endif

  // Pick the requester that wins an IDLE arbitration this cycle.
  always_comb begin
    w_winner = 1'b0;
    if (req == 2'b11) begin
      w_winner = ~r_last;
    end else if (req[1]) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
`ifdef PERIPH_ARB_LOCK_EN
    // A pending lock keeps the previous owner, unless four locked grants are used up.
    w_lock_hit = r_lock_pend && (r_lock_cnt < 3'd4) && req[r_last];
    if (w_lock_hit) begin
      w_winner = r_last;
    end else begin
      w_winner = w_winner;
    end
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE waits for a request, ACCESS and RESP last one cycle each.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus, grant, done and rdata.
  always_comb begin
    w_grant_nxt = 2'b00;
    w_done_nxt  = 2'b00;
    w_rdata_nxt = r_rdata;
    w_paddr_nxt = 32'h0000_0000;
    w_pmode_nxt = 1'b0;
    w_pdata_nxt = 32'h0000_0000;
    w_last_nxt  = r_last;
`ifdef PERIPH_ARB_LOCK_EN
    w_lock_cnt_nxt  = r_lock_cnt;
    w_lock_pend_nxt = r_lock_pend;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          // Capture the winner's request; later input changes are ignored.
          w_grant_nxt = w_winner ? 2'b10 : 2'b01;
          w_paddr_nxt = w_winner ? req_address[63:32] : req_address[31:0];
          w_pdata_nxt = w_winner ? req_wdata[63:32] : req_wdata[31:0];
          w_pmode_nxt = req_mode[w_winner];
          w_last_nxt  = w_winner;
`ifdef PERIPH_ARB_LOCK_EN
          if (r_lock_cnt == 3'd4) begin
            w_lock_cnt_nxt = 3'd0;
          end else if (req_lock[w_winner]) begin
            w_lock_cnt_nxt = r_lock_cnt + 3'd1;
          end else begin
            w_lock_cnt_nxt = 3'd0;
          end
`endif
        end else begin
          w_grant_nxt = 2'b00;
        end
      end
      S_ACCESS: begin
        // Bus is released for RESP; the owner keeps grant and receives done.
        w_grant_nxt = r_grant;
        w_done_nxt  = r_grant;
        if (r_pmode) begin
          w_rdata_nxt = r_rdata;
        end else begin
          w_rdata_nxt = periph_data_out;
        end
      end
      S_RESP: begin
        w_grant_nxt = 2'b00;
`ifdef PERIPH_ARB_LOCK_EN
        w_lock_pend_nxt = r_grant[1] ? req_lock[1] : req_lock[0];
`endif
      end
      default: begin
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  // Output and arbitration-history registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= 2'b00;
      r_done  <= 2'b00;
      r_rdata <= 32'h0000_0000;
      r_paddr <= 32'h0000_0000;
      r_pmode <= 1'b0;
      r_pdata <= 32'h0000_0000;
      r_last  <= 1'b1;
    end else begin
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_rdata <= w_rdata_nxt;
      r_paddr <= w_paddr_nxt;
      r_pmode <= w_pmode_nxt;
      r_pdata <= w_pdata_nxt;
      r_last  <= w_last_nxt;
    end
  end

`ifdef PERIPH_ARB_LOCK_EN
  // Lock bookkeeping registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_cnt  <= 3'd0;
      r_lock_pend <= 1'b0;
    end else begin
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_lock_pend <= w_lock_pend_nxt;
    end
  end
`endif

  assign grant          = r_grant;
  assign done           = r_done;
  assign rdata          = r_rdata;
  assign periph_address = r_paddr;
  assign periph_mode    = r_pmode;
  assign periph_data_in = r_pdata;

endmodule
